sd_crc_stream: RTL and testbench

Parametrised, streaming CRC engine for the SD-card command/data path, replacing the fixed combinational CRC7 step with a framed, handshaked block. It accepts a message in DATA_W-bit beats and runs in one of two modes. In generate mode it emits the CRC, padded to whole beats, so it can be appended to an outgoing frame. In check mode it consumes the received CRC beats and flags a match. It sits between the SD command/data shifters and the card-side serialiser.

---
 rtl/sd_crc_pkg.sv | 18 +
 rtl/sd_crc_update.sv | 25 ++
 rtl/sd_crc_stream.sv | 172 +++++++++++++++++
 tb/tb_sd_crc_stream.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_crc_pkg.sv
// rtl/sd_crc_pkg.sv - shared states, SD polynomials and beat-count helper for the streaming CRC
package sd_crc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      EMIT,
      RXCRC
   } state_t;

   localparam logic [6:0]  CRC7_POLY  = 7'h09;
   localparam logic [15:0] CRC16_POLY = 16'h1021;

   function automatic int nb_beats(input int crc_w, input int data_w);
      return (crc_w + data_w - 1) / data_w;
   endfunction

endpackage

// File: rtl/sd_crc_update.sv
// rtl/sd_crc_update.sv - combinational DATA_W-bit unrolled Galois LFSR step, MSB first
module sd_crc_update #(
   parameter int               CRC_W  = 7,
   parameter logic [CRC_W-1:0] POLY   = 7'h09,
   parameter int               DATA_W = 1
) (
   input  logic [CRC_W-1:0]  i_crc,
   input  logic [DATA_W-1:0] i_data,
   output logic [CRC_W-1:0]  o_crc
);

   logic [CRC_W-1:0] w_acc;
   logic             w_fb;

   always_comb begin
      w_acc = i_crc;
      w_fb  = 1'b0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         w_fb  = w_acc[CRC_W-1] ^ i_data[i];
         w_acc = {w_acc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
      end
      o_crc = w_acc;
   end

endmodule

// File: rtl/sd_crc_stream.sv
// rtl/sd_crc_stream.sv - framed, handshaked streaming CRC generator/checker for the SD path
module sd_crc_stream
   import sd_crc_pkg::*;
#(
   parameter int               CRC_W   = 7,
   parameter logic [CRC_W-1:0] POLY    = CRC7_POLY,
   parameter int               DATA_W  = 1,
   parameter logic [CRC_W-1:0] INIT    = '0,
   parameter logic             PAD_VAL = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_mode,
   input  logic              i_abort,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   input  logic              i_in_last,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic [CRC_W-1:0]  o_crc_value,
   output logic              o_done,
   output logic              o_crc_ok
);

   localparam int NB = nb_beats(CRC_W, DATA_W);
   localparam int FW = NB * DATA_W;
   localparam int NP = FW - CRC_W;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [FW-1:0] L_ONE    = FW'(1);
   localparam logic [FW-1:0] PAD_MASK = PAD_VAL ? ((L_ONE << NP) - L_ONE) : '0;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CRC_W-1:0]  r_crc;
   logic              r_mode;
   logic [IW-1:0]     r_idx;
   logic [FW-1:0]     r_rx;
   logic              r_done;
   logic              r_crc_ok;

   logic [CRC_W-1:0]  w_crc_upd;
   logic              w_in_ready;
   logic              w_out_valid;
   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_last_idx;
   logic [FW-1:0]     w_frame;
   logic [FW-1:0]     w_rx_nxt;
   logic [DATA_W-1:0] w_out_data;

   sd_crc_update #(
      .CRC_W  (CRC_W),
      .POLY   (POLY),
      .DATA_W (DATA_W)
   ) u_update (
      .i_crc  (r_crc),
      .i_data (i_in_data),
      .o_crc  (w_crc_upd)
   );

   assign w_last_idx = (r_idx == IW'(NB - 1));
   assign w_in_fire  = i_in_valid && w_in_ready;
   assign w_out_fire = w_out_valid && i_out_ready;
   // CRC left-justified in the padded frame; pad bits occupy the LSBs of the last beat
   assign w_frame    = (FW'(r_crc) << NP) | PAD_MASK;
   assign w_rx_nxt   = (r_rx << DATA_W) | FW'(i_in_data);

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) w_state_nxt = ACCUM;
         end
         ACCUM: begin
            w_in_ready = 1'b1;
            if (i_in_valid && i_in_last) w_state_nxt = r_mode ? RXCRC : EMIT;
         end
         EMIT: begin
            w_out_valid = 1'b1;
            if (i_out_ready && w_last_idx) w_state_nxt = IDLE;
         end
         RXCRC: begin
            w_in_ready = 1'b1;
            if (i_in_valid && w_last_idx) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      // abort also blocks any handshake in its own cycle
      if (i_abort) begin
         w_state_nxt = IDLE;
         w_in_ready  = 1'b0;
         w_out_valid = 1'b0;
      end
   end

   always_comb begin
      w_out_data = '0;
      for (int k = 0; k < NB; k++) begin
         if (int'(r_idx) == k) w_out_data = w_frame[FW-1-k*DATA_W -: DATA_W];
      end
      if (!w_out_valid) w_out_data = '0;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_crc    <= INIT;
         r_mode   <= 1'b0;
         r_idx    <= '0;
         r_rx     <= '0;
         r_done   <= 1'b0;
         r_crc_ok <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= 1'b0;
         if (i_abort) begin
            r_idx <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (i_start) begin
                     r_crc    <= INIT;
                     r_mode   <= i_mode;
                     r_crc_ok <= 1'b0;
                     r_rx     <= '0;
                     r_idx    <= '0;
                  end
               end
               ACCUM: begin
                  if (w_in_fire) r_crc <= w_crc_upd;
               end
               EMIT: begin
                  if (w_out_fire) begin
                     if (w_last_idx) begin
                        r_idx  <= '0;
                        r_done <= 1'b1;
                     end else begin
                        r_idx <= r_idx + 1'b1;
                     end
                  end
               end
               RXCRC: begin
                  if (w_in_fire) begin
                     r_rx <= w_rx_nxt;
                     if (w_last_idx) begin
                        r_idx    <= '0;
                        r_done   <= 1'b1;
                        r_crc_ok <= ((w_rx_nxt >> NP) == FW'(r_crc));
                     end else begin
                        r_idx <= r_idx + 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_in_ready  = w_in_ready;
   assign o_out_valid = w_out_valid;
   assign o_out_data  = w_out_data;
   assign o_crc_value = r_crc;
   assign o_done      = r_done;
   assign o_crc_ok    = r_crc_ok;

endmodule

// File: tb/tb_sd_crc_stream.sv
// tb/tb_sd_crc_stream.sv - scoreboard bench for sd_crc_stream in CRC7/8-bit, CRC7/1-bit and CRC16/4-bit forms
module tb_sd_crc_stream;
   import sd_crc_pkg::*;

   typedef struct packed {
      logic [31:0] cyc;
      logic        ok;
      logic [15:0] crc;
   } done_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst8 = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // CRC7, 8-bit beats
   logic start8, mode8, abort8, vld8, last8, ordy8;
   logic [7:0] dat8, od8;
   logic ir8, ov8, done8, ok8;
   logic [6:0] crc8;
   // CRC7, 1-bit beats
   logic start1, mode1, abort1, vld1, last1, ordy1;
   logic [0:0] dat1, od1;
   logic ir1, ov1, done1, ok1;
   logic [6:0] crc1;
   // CRC16, 4-bit beats
   logic start16, mode16, abort16, vld16, last16, ordy16;
   logic [3:0] dat16, od16;
   logic ir16, ov16, done16, ok16;
   logic [15:0] crc16;

   logic [7:0] b8q[$];
   logic [0:0] b1q[$];
   logic [3:0] b16q[$];
   done_t dq8[$];
   done_t dq1[$];
   done_t dq16[$];
   done_t e8, e1, e16;
   logic hold1;
   logic [0:0] held1;

   sd_crc_stream #(.CRC_W(7), .POLY(7'h09), .DATA_W(8), .INIT(7'h00), .PAD_VAL(1'b1)) u_d8 (
      .i_clk(clk), .i_rst(rst8), .i_start(start8), .i_mode(mode8), .i_abort(abort8),
      .i_in_valid(vld8), .o_in_ready(ir8), .i_in_data(dat8), .i_in_last(last8),
      .o_out_valid(ov8), .i_out_ready(ordy8), .o_out_data(od8),
      .o_crc_value(crc8), .o_done(done8), .o_crc_ok(ok8));

   sd_crc_stream #(.CRC_W(7), .POLY(7'h09), .DATA_W(1), .INIT(7'h00), .PAD_VAL(1'b1)) u_d1 (
      .i_clk(clk), .i_rst(rst), .i_start(start1), .i_mode(mode1), .i_abort(abort1),
      .i_in_valid(vld1), .o_in_ready(ir1), .i_in_data(dat1), .i_in_last(last1),
      .o_out_valid(ov1), .i_out_ready(ordy1), .o_out_data(od1),
      .o_crc_value(crc1), .o_done(done1), .o_crc_ok(ok1));

   sd_crc_stream #(.CRC_W(16), .POLY(CRC16_POLY), .DATA_W(4), .INIT(16'h0000), .PAD_VAL(1'b1)) u_d16 (
      .i_clk(clk), .i_rst(rst), .i_start(start16), .i_mode(mode16), .i_abort(abort16),
      .i_in_valid(vld16), .o_in_ready(ir16), .i_in_data(dat16), .i_in_last(last16),
      .o_out_valid(ov16), .i_out_ready(ordy16), .o_out_data(od16),
      .o_crc_value(crc16), .o_done(done16), .o_crc_ok(ok16));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: output seen with nothing expected", nm);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitors: pop expectations whenever a DUT presents a beat or a done pulse
   always @(negedge clk) begin
      if (ov8 && ordy8) begin
         if (b8q.size() == 0) unexpected("d8_beat");
         else check("d8_beat", 32'(od8), 32'(b8q.pop_front()));
      end
      if (done8) begin
         if (dq8.size() == 0) unexpected("d8_done");
         else begin
            e8 = dq8.pop_front();
            check("d8_done_cycle", cyc, e8.cyc);
            check("d8_crc_ok", 32'(ok8), 32'(e8.ok));
            check("d8_crc_value", 32'(crc8), 32'(e8.crc));
         end
      end
   end

   always @(negedge clk) begin
      if (hold1) begin
         check("d1_hold_valid", 32'(ov1), 32'd1);
         check("d1_hold_data", 32'(od1), 32'(held1));
      end
      hold1 = ov1 && !ordy1;
      held1 = od1;
      if (ov1 && ordy1) begin
         if (b1q.size() == 0) unexpected("d1_beat");
         else check("d1_beat", 32'(od1), 32'(b1q.pop_front()));
      end
      if (done1) begin
         if (dq1.size() == 0) unexpected("d1_done");
         else begin
            e1 = dq1.pop_front();
            check("d1_done_cycle", cyc, e1.cyc);
            check("d1_crc_value", 32'(crc1), 32'(e1.crc));
         end
      end
   end

   always @(negedge clk) begin
      if (ov16 && ordy16) begin
         if (b16q.size() == 0) unexpected("d16_beat");
         else check("d16_beat", 32'(od16), 32'(b16q.pop_front()));
      end
      if (done16) begin
         if (dq16.size() == 0) unexpected("d16_done");
         else begin
            e16 = dq16.pop_front();
            check("d16_done_cycle", cyc, e16.cyc);
            check("d16_crc_value", 32'(crc16), 32'(e16.crc));
         end
      end
   end

   task automatic frame8(input logic md, input logic [39:0] msg, input logic [7:0] tail,
                         input logic mid_start, input logic [6:0] ecrc,
                         input logic [7:0] ebeat, input logic eok);
      int s;
      s = cyc;
      if (!md) b8q.push_back(ebeat);
      dq8.push_back('{cyc: 32'(s + 7), ok: eok, crc: 16'(ecrc)});
      start8 = 1'b1;
      mode8  = md;
      step();
      start8 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         vld8  = 1'b1;
         dat8  = msg[39-8*i -: 8];
         last8 = (i == 4);
         if (mid_start && i == 2) begin
            start8 = 1'b1;
            mode8  = ~md;
         end else begin
            start8 = 1'b0;
         end
         step();
      end
      start8 = 1'b0;
      last8  = 1'b0;
      if (md) begin
         vld8 = 1'b1;
         dat8 = tail;
         step();
      end
      vld8 = 1'b0;
      repeat (4) step();
   endtask

   task automatic abort8_test();
      logic [39:0] msg;
      msg = 40'h40_0000_0000;
      start8 = 1'b1;
      mode8  = 1'b0;
      step();
      start8 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         vld8   = 1'b1;
         dat8   = msg[39-8*i -: 8];
         last8  = 1'b0;
         abort8 = (i == 3);
         step();
      end
      abort8 = 1'b0;
      vld8   = 1'b0;
      check("abort_in_ready", 32'(ir8), 32'd0);
      check("abort_out_valid", 32'(ov8), 32'd0);
      repeat (3) step();
      check("abort_idle_in_ready", 32'(ir8), 32'd0);
   endtask

   task automatic rst_emit_test();
      logic [39:0] msg;
      msg   = 40'h40_0000_0000;
      ordy8 = 1'b0;
      start8 = 1'b1;
      mode8  = 1'b0;
      step();
      start8 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         vld8  = 1'b1;
         dat8  = msg[39-8*i -: 8];
         last8 = (i == 4);
         step();
      end
      vld8  = 1'b0;
      last8 = 1'b0;
      check("emit_valid", 32'(ov8), 32'd1);
      check("emit_data", 32'(od8), 32'h95);
      #2 rst8 = 1'b1;
      #1;
      check("rst_out_valid", 32'(ov8), 32'd0);
      check("rst_crc_value", 32'(crc8), 32'd0);
      check("rst_out_data", 32'(od8), 32'd0);
      check("rst_in_ready", 32'(ir8), 32'd0);
      step();
      rst8  = 1'b0;
      ordy8 = 1'b1;
      step();
   endtask

   task automatic frame1();
      int s;
      logic [39:0] msg;
      logic [6:0]  exp_bits;
      msg = 40'h40_0000_0000;
      exp_bits = 7'b1001010;
      s = cyc;
      for (int k = 6; k >= 0; k--) b1q.push_back(exp_bits[k]);
      dq1.push_back('{cyc: 32'(s + 1 + 40 + 7 + 3), ok: 1'b0, crc: 16'h004A});
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         vld1  = 1'b1;
         dat1  = msg[39-i];
         last1 = (i == 39);
         step();
      end
      vld1  = 1'b0;
      last1 = 1'b0;
      step();
      step();
      ordy1 = 1'b0;
      repeat (3) step();
      ordy1 = 1'b1;
      repeat (8) step();
   endtask

   task automatic frame16();
      int s;
      s = cyc;
      b16q.push_back(4'h7);
      b16q.push_back(4'hF);
      b16q.push_back(4'hA);
      b16q.push_back(4'h1);
      dq16.push_back('{cyc: 32'(s + 1 + 1024 + 4), ok: 1'b0, crc: 16'h7FA1});
      start16 = 1'b1;
      step();
      start16 = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         vld16  = 1'b1;
         dat16  = 4'hF;
         last16 = (i == 1023);
         step();
      end
      vld16  = 1'b0;
      last16 = 1'b0;
      repeat (8) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      {start8, mode8, abort8, vld8, last8, dat8} = '0;
      {start1, mode1, abort1, vld1, last1, dat1} = '0;
      {start16, mode16, abort16, vld16, last16, dat16} = '0;
      ordy8 = 1'b1;
      ordy1 = 1'b1;
      ordy16 = 1'b1;
      hold1 = 1'b0;
      held1 = '0;
      #1;
      check("reset_out_valid", 32'(ov8), 32'd0);
      check("reset_in_ready", 32'(ir8), 32'd0);
      check("reset_done", 32'(done8), 32'd0);
      check("reset_crc_ok", 32'(ok8), 32'd0);
      check("reset_crc_value", 32'(crc8), 32'd0);
      check("reset_out_data", 32'(od8), 32'd0);
      check("reset_crc16_value", 32'(crc16), 32'd0);
      repeat (2) step();
      rst  = 1'b0;
      rst8 = 1'b0;
      step();

      frame8(1'b0, 40'h40_0000_0000, 8'h00, 1'b0, 7'h4A, 8'h95, 1'b0);
      frame8(1'b0, 40'h48_0000_01AA, 8'h00, 1'b0, 7'h43, 8'h87, 1'b0);
      frame8(1'b0, 40'h51_0000_0000, 8'h00, 1'b0, 7'h2A, 8'h55, 1'b0);
      frame8(1'b1, 40'h40_0000_0000, 8'h95, 1'b0, 7'h4A, 8'h00, 1'b1);
      frame8(1'b1, 40'h40_0000_0000, 8'h97, 1'b0, 7'h4A, 8'h00, 1'b0);
      frame8(1'b1, 40'h40_0000_0000, 8'h94, 1'b0, 7'h4A, 8'h00, 1'b1);
      abort8_test();
      frame8(1'b0, 40'h40_0000_0000, 8'h00, 1'b1, 7'h4A, 8'h95, 1'b0);
      rst_emit_test();
      frame8(1'b0, 40'h48_0000_01AA, 8'h00, 1'b0, 7'h43, 8'h87, 1'b0);

      frame1();
      frame16();

      repeat (5) step();
      check("d8_beats_left", 32'(b8q.size()), 32'd0);
      check("d8_dones_left", 32'(dq8.size()), 32'd0);
      check("d1_beats_left", 32'(b1q.size()), 32'd0);
      check("d1_dones_left", 32'(dq1.size()), 32'd0);
      check("d16_beats_left", 32'(b16q.size()), 32'd0);
      check("d16_dones_left", 32'(dq16.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
